// File: rtl/tdc_therm_accum.sv
// tdc_therm_accum: pipelined thermometer popcount, windowed accumulation, one-entry Avalon-ST output.
// Optional bubble filter stage: define TDC_BUBBLE_FILTER_EN.
module tdc_therm_accum #(
   parameter int C_IN_WIDTH = 256,
   parameter int C_WIN_LOG2 = 4,
   localparam int C_CNT_WIDTH = $clog2(C_IN_WIDTH + 1),
   localparam int C_SUM_WIDTH = C_CNT_WIDTH + C_WIN_LOG2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [C_IN_WIDTH-1:0]  S_AVST_DATA,
   input  logic                   S_AVST_VALID,
   output logic [C_SUM_WIDTH-1:0] M_AVST_DATA,
   output logic                   M_AVST_VALID,
   input  logic                   M_AVST_READY,
   input  logic                   clr,
   output logic                   overflow
);
   localparam int C_GROUPS = C_IN_WIDTH / 16;
   localparam int C_QUADS = (C_GROUPS + 3) / 4;
   localparam int C_NW = C_WIN_LOG2 + 1;
   localparam logic [C_NW-1:0] C_WIN = C_NW'(1 << C_WIN_LOG2);
   typedef enum logic {ST_FIRST, ST_ACC} state_t;
   logic [C_IN_WIDTH-1:0] in_q, p1_src;
   logic in_vld_q, p1_src_vld;
   logic [C_GROUPS-1:0][4:0] grp_d, grp_q;
   logic grp_vld_q;
   logic [C_QUADS-1:0][6:0] quad_d, quad_q;
   logic quad_vld_q;
   logic [C_CNT_WIDTH-1:0] cnt_d, cnt_q;
   logic cnt_vld_q;
   state_t state_q, state_d;
   logic [C_SUM_WIDTH-1:0] acc_q, acc_d, sum, data_q, data_d;
   logic [C_NW-1:0] n_q, n_d, n_inc;
   logic done, load, vld_q, vld_d, ovf_q, ovf_d;
`ifdef TDC_BUBBLE_FILTER_EN
   logic [C_IN_WIDTH+1:0] pad;
   logic [C_IN_WIDTH-1:0] p0_d, p0_q;
   logic p0_vld_q;
   // Edges of the chain are pinned: below bit 0 reads as 1, above the top as 0.
   assign pad = {1'b0, in_q, 1'b1};
   assign p0_d = (pad[C_IN_WIDTH-1:0] & pad[C_IN_WIDTH:1]) |
                 (pad[C_IN_WIDTH:1] & pad[C_IN_WIDTH+1:2]) |
                 (pad[C_IN_WIDTH-1:0] & pad[C_IN_WIDTH+1:2]);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         p0_q <= '0;
         p0_vld_q <= 1'b0;
      end else begin
         p0_q <= p0_d;
         p0_vld_q <= in_vld_q;
      end
   assign p1_src = p0_q;
   assign p1_src_vld = p0_vld_q;
`else
   assign p1_src = in_q;
   assign p1_src_vld = in_vld_q;
`endif
   always_comb begin
      grp_d = '0;
      for (int g = 0; g < C_GROUPS; g++)
         for (int b = 0; b < 16; b++)
            grp_d[g] = grp_d[g] + 5'(p1_src[16*g+b]);
   end
   always_comb begin
      quad_d = '0;
      for (int q = 0; q < C_QUADS; q++)
         for (int j = 0; j < 4; j++)
            if (4*q + j < C_GROUPS)
               quad_d[q] = quad_d[q] + 7'(grp_q[4*q+j]);
   end
   always_comb begin
      cnt_d = '0;
      for (int q = 0; q < C_QUADS; q++)
         cnt_d = cnt_d + C_CNT_WIDTH'(quad_q[q]);
   end
   // A full output register is only overwritten when it drains in the same cycle.
   always_comb begin
      sum = (state_q == ST_FIRST) ? C_SUM_WIDTH'(cnt_q) : acc_q + C_SUM_WIDTH'(cnt_q);
      n_inc = (state_q == ST_FIRST) ? C_NW'(1) : n_q + C_NW'(1);
      done = cnt_vld_q && (n_inc == C_WIN);
      state_d = !cnt_vld_q ? state_q : done ? ST_FIRST : ST_ACC;
      acc_d = cnt_vld_q ? sum : acc_q;
      n_d = !cnt_vld_q ? n_q : done ? '0 : n_inc;
      load = done & (~vld_q | M_AVST_READY);
      vld_d = load | (vld_q & ~M_AVST_READY);
      data_d = load ? sum : data_q;
      ovf_d = (done & vld_q & ~M_AVST_READY) | (ovf_q & ~clr);
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         in_q <= '0;
         in_vld_q <= 1'b0;
         grp_q <= '0;
         grp_vld_q <= 1'b0;
         quad_q <= '0;
         quad_vld_q <= 1'b0;
         cnt_q <= '0;
         cnt_vld_q <= 1'b0;
         state_q <= ST_FIRST;
         acc_q <= '0;
         n_q <= '0;
         data_q <= '0;
         vld_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         in_q <= S_AVST_DATA;
         in_vld_q <= S_AVST_VALID;
         grp_q <= grp_d;
         grp_vld_q <= p1_src_vld;
         quad_q <= quad_d;
         quad_vld_q <= grp_vld_q;
         cnt_q <= cnt_d;
         cnt_vld_q <= quad_vld_q;
         state_q <= state_d;
         acc_q <= acc_d;
         n_q <= n_d;
         data_q <= data_d;
         vld_q <= vld_d;
         ovf_q <= ovf_d;
      end
   assign M_AVST_DATA = data_q;
   assign M_AVST_VALID = vld_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_tdc_therm_accum.sv
// tb_tdc_therm_accum: directed and randomized checks of tdc_therm_accum against a window/latency model.
module tb_tdc_therm_accum;
   localparam int W = 256;
   localparam int WL = 2;
   localparam int NWIN = 1 << WL;
   localparam int SW = $clog2(W + 1) + WL;
`ifdef TDC_BUBBLE_FILTER_EN
   localparam int LAT = 5;
   localparam int BUB = 32;
`else
   localparam int LAT = 4;
   localparam int BUB = 28;
`endif
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [W-1:0] s_data = '0;
   logic s_valid = 1'b0;
   logic [SW-1:0] m_data;
   logic m_valid;
   logic m_ready = 1'b1;
   logic clr = 1'b0;
   logic ovf;
   int compared = 0;
   int mismatched = 0;
   int cyc = 0, w_n = 0, w_sum = 0;
   int m_vld = 0, m_dat = 0, m_ovf = 0;
   int qe[$], qv[$];

   tdc_therm_accum #(.C_IN_WIDTH(W), .C_WIN_LOG2(WL)) dut (
      .clk(clk), .rst(rst), .S_AVST_DATA(s_data), .S_AVST_VALID(s_valid),
      .M_AVST_DATA(m_data), .M_AVST_VALID(m_valid), .M_AVST_READY(m_ready),
      .clr(clr), .overflow(ovf));

   always #5 clk = ~clk;

   function automatic int ones(input logic [W-1:0] d);
      int c = 0;
      logic l, r, b;
      for (int i = 0; i < W; i++) begin
         l = (i == 0) ? 1'b1 : d[i-1];
         r = (i == W-1) ? 1'b0 : d[i+1];
`ifdef TDC_BUBBLE_FILTER_EN
         b = (l & d[i]) | (d[i] & r) | (l & r);
`else
         b = d[i];
`endif
         c += int'(b);
      end
      return c;
   endfunction

   function automatic logic [W-1:0] therm(input int n);
      logic [W-1:0] t = '0;
      for (int i = 0; i < n; i++) t[i] = 1'b1;
      return t;
   endfunction

   // Reference: windows closed by sample count, result visible LAT edges after the last sample.
   initial forever begin
      int v;
      bit done;
      @(posedge clk or negedge rst);
      if (!rst) begin
         w_n = 0; w_sum = 0; m_vld = 0; m_dat = 0; m_ovf = 0;
         qe.delete(); qv.delete();
      end else begin
         cyc++;
         done = 0;
         v = 0;
         if (qe.size() > 0 && qe[0] == cyc) begin
            done = 1;
            v = qv.pop_front();
            void'(qe.pop_front());
         end
         if (done && m_vld == 1 && !m_ready) m_ovf = 1;
         else if (clr) m_ovf = 0;
         if (done && (m_vld == 0 || m_ready)) begin
            m_vld = 1;
            m_dat = v;
         end else if (m_vld == 1 && m_ready) m_vld = 0;
         if (s_valid) begin
            w_sum += ones(s_data);
            w_n++;
            if (w_n == NWIN) begin
               qe.push_back(cyc + LAT);
               qv.push_back(w_sum);
               w_n = 0;
               w_sum = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      compared += 3;
      if (m_valid !== 1'(m_vld)) begin
         mismatched++;
         $display("FAIL valid @%0t: got %b expected %0d", $time, m_valid, m_vld);
      end
      if (m_data !== SW'(m_dat)) begin
         mismatched++;
         $display("FAIL data @%0t: got %0d expected %0d", $time, m_data, m_dat);
      end
      if (ovf !== 1'(m_ovf)) begin
         mismatched++;
         $display("FAIL overflow @%0t: got %b expected %0d", $time, ovf, m_ovf);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic drv(input logic [W-1:0] d);
      s_data = d;
      s_valid = 1'b1;
      idle(1);
      s_valid = 1'b0;
   endtask

   task automatic win(input int n, input int gap);
      for (int i = 0; i < NWIN; i++) begin
         drv(therm(n));
         if (i < NWIN-1) idle(gap);
      end
   endtask

   initial begin
      idle(3);
      chk("reset_valid", 32'(m_valid), 0);
      chk("reset_data", 32'(m_data), 0);
      chk("reset_ovf", 32'(ovf), 0);
      rst = 1'b1;
      idle(2);
      win(100, 0);
      idle(LAT-1);
      chk("s1_not_early", 32'(m_valid), 0);
      idle(1);
      chk("s1_valid", 32'(m_valid), 1);
      chk("s1_data", 32'(m_data), 400);
      idle(1);
      chk("s1_one_cycle", 32'(m_valid), 0);
      win(W, 0);
      idle(LAT);
      chk("s2_data", 32'(m_data), 1024);
      chk("s2_ovf", 32'(ovf), 0);
      idle(2);
      win(100, 2);
      idle(LAT-1);
      chk("s3_not_early", 32'(m_valid), 0);
      idle(1);
      chk("s3_data", 32'(m_data), 400);
      idle(2);
      m_ready = 1'b0;
      win(100, 0);
      win(50, 0);
      idle(LAT+1);
      chk("s4_held", 32'(m_data), 400);
      chk("s4_valid", 32'(m_valid), 1);
      chk("s4_ovf", 32'(ovf), 1);
      m_ready = 1'b1;
      idle(1);
      chk("s4_drained", 32'(m_valid), 0);
      chk("s4_ovf_sticky", 32'(ovf), 1);
      clr = 1'b1;
      idle(1);
      clr = 1'b0;
      chk("s4_clr", 32'(ovf), 0);
      m_ready = 1'b0;
      win(10, 0);
      idle(LAT);
      chk("s4_first_40", 32'(m_data), 40);
      win(20, 0);
      idle(LAT-1);
      m_ready = 1'b1;
      idle(1);
      chk("s4_swap_valid", 32'(m_valid), 1);
      chk("s4_swap_data", 32'(m_data), 80);
      chk("s4_swap_ovf", 32'(ovf), 0);
      idle(1);
      m_ready = 1'b0;
      win(10, 0);
      idle(LAT);
      drv(therm(30));
      drv(therm(30));
      rst = 1'b0;
      #1;
      chk("s5_rst_valid", 32'(m_valid), 0);
      chk("s5_rst_data", 32'(m_data), 0);
      idle(2);
      rst = 1'b1;
      m_ready = 1'b1;
      win(10, 0);
      idle(LAT);
      chk("s5_data", 32'(m_data), 40);
      idle(2);
      for (int i = 0; i < NWIN; i++) drv(W'(8'hF7));
      idle(LAT);
      chk("s6_bubble", 32'(m_data), BUB);
      for (int i = 0; i < 3000; i++) begin
         logic [W-1:0] t;
         t = therm(int'($urandom_range(0, W)));
         if ($urandom % 4 == 0) t[$urandom_range(0, W-1)] ^= 1'b1;
         s_data = t;
         s_valid = ($urandom % 4) != 0;
         m_ready = ($urandom % 3) != 0;
         clr = ($urandom % 16) == 0;
         rst = !(i >= 1500 && i < 1503);
         idle(1);
      end
      s_valid = 1'b0;
      clr = 1'b0;
      m_ready = 1'b1;
      idle(10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/tdc_therm_accum.md
# tdc_therm_accum

Downstream stage of the carry-chain TDC capture block. It consumes the synchronized thermometer-code samples on the Avalon-ST sink and converts each to a binary ones-count in a pipelined popcount. It sums 2^C_WIN_LOG2 consecutive valid samples into one window result. The result is presented on a ready/valid Avalon-ST source with single-entry output buffering and a sticky overflow flag, because the upstream stage cannot be stalled.

## Interface
- C_IN_WIDTH, 256: thermometer width; must match the upstream C_OUT_WIDTH; multiple of 16.
- C_WIN_LOG2, 4: log2 of the samples per window; legal range 0..8.
- C_CNT_WIDTH (localparam): $clog2(C_IN_WIDTH+1); 9 at the default width.
- C_SUM_WIDTH (localparam): C_CNT_WIDTH + C_WIN_LOG2.
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-low reset.
- S_AVST_DATA  in  C_IN_WIDTH  thermometer sample.
- S_AVST_VALID  in  1  sample qualifier; no ready signal exists, so every valid sample must be consumed.
- M_AVST_DATA  out  C_SUM_WIDTH  window sum of ones-counts.
- M_AVST_VALID  out  1  window result valid.
- M_AVST_READY  in  1  downstream accept.
- clr  in  1  synchronous clear of the overflow flag.
- overflow  out  1  sticky flag: a window result was dropped.

## Operation
- Popcount pipeline: no stall path; a valid bit travels alongside the data.
  - P1: per-16-bit-group counts are registered.
  - P2: groups are summed in fours.
  - P3: the final sum is registered as a C_CNT_WIDTH count.
- Accumulator FSM, two states:
  - FIRST: on a valid count, acc <= count, n <= 1, and the FSM moves to ACC. If C_WIN_LOG2 = 0, the window completes immediately and the FSM stays in FIRST.
  - ACC: on a valid count, acc <= acc + count and n <= n + 1. When n + 1 == 2^C_WIN_LOG2, the window completes with result acc + count, and the FSM returns to FIRST.
  - The accumulator is sized C_SUM_WIDTH and cannot overflow arithmetically.
- Output register, one entry:
  - A window completes while the register is empty, or while it is being drained in the same cycle (M_AVST_VALID & M_AVST_READY): the result is loaded and M_AVST_VALID = 1.
  - A window completes while the register is full and not being drained: the result is dropped and overflow is set. The held result is unchanged.
  - A handshake with no new completion in the same cycle: M_AVST_VALID <= 0. M_AVST_DATA holds its last value.
  - While valid is high, M_AVST_DATA must stay stable until accepted.
- overflow is cleared by clr. If clr and a new drop happen in the same cycle, overflow = 1 (the set wins).
- Gaps in S_AVST_VALID are allowed anywhere. A window is defined by its sample count, not by cycles.

## Timing
- Reset values, applied asynchronously on rst = 0: M_AVST_DATA = 0, M_AVST_VALID = 0, overflow = 0, FSM = FIRST, n = 0, all pipeline valids = 0.
- Reset asserted mid-window discards the partial window and all in-flight samples. The first sample after reset release starts a new window.
- Latency: a valid sample sampled at edge k has its count registered at edge k+3 (k+4 with the filter enabled). The window containing that sample as its last sample shows M_AVST_VALID = 1 after edge k+4 (k+5 with the filter enabled).
- Throughput: one sample per clock, sustained.
- M_AVST_READY is ignored while M_AVST_VALID = 0.

## Configuration
- TDC_BUBBLE_FILTER_EN defined:
  - An extra registered stage P0 precedes P1. It replaces each bit i with maj(d[i-1], d[i], d[i+1]), using d[-1] = 1 and d[C_IN_WIDTH] = 0.
  - This removes single-bit bubbles and adds 1 cycle of latency.
- Not defined: raw samples feed P1 directly and the latency is as stated without the filter.

## Test plan
All scenarios use C_IN_WIDTH = 256, C_WIN_LOG2 = 2, M_AVST_READY = 1 unless stated.
- Four back-to-back samples with bits [99:0] set -> M_AVST_DATA = 400, M_AVST_VALID = 1 four edges after the fourth sample (five with the filter), high for exactly one cycle.
- Four all-ones samples -> M_AVST_DATA = 1024 (fits 11 bits), overflow = 0.
- Scenario 1 stimulus with valid asserted every third cycle -> same result, 400, timed from the fourth valid sample.
- M_AVST_READY = 0 across two completed windows (counts 100 and 50 per sample) -> M_AVST_DATA = 400 held, overflow = 1. Raise ready -> one handshake, then valid = 0. Pulse clr -> overflow = 0. A window completing in the same cycle as a handshake loads without setting overflow.
- rst = 0 after two samples of a window -> outputs 0 immediately. Four samples of 10 ones after release -> result 40.
- Sample with low byte 8'b11110111 and all upper bits 0, four times -> result 32 with TDC_BUBBLE_FILTER_EN defined, 28 without it.
